// File: rtl/cs161_ctrl_pkg.sv
// cs161_ctrl_pkg: shared constants for the cs161 MIPS control units.
// Contents: field widths, opcode/funct constants, ALU select codes,
// multi-cycle state encodings and a small opcode classification helper.
package cs161_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    // ALU function selects
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_WB_MEM   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_EXEC_I   = 4'd9,
        ST_WB_I     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    // Non-R-type opcodes this control unit knows how to sequence.
    function automatic logic is_known_itype(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/cs161_multicycle_control_if.sv
// cs161_multicycle_control_if: datapath <-> control unit bundle.
// master: control unit (drives control lines, receives IR fields and mem_ready).
// slave : datapath/memory side (drives instr_op, funct, mem_ready).
// Signals: instr_op, funct, mem_ready, reg_dst, branch, mem_read, mem_to_reg,
// alu_op, mem_write, alu_src, reg_write, ir_write, pc_write, illegal, state_dbg.
interface cs161_multicycle_control_if;
    import cs161_ctrl_pkg::*;

    logic [OP_W-1:0]    instr_op;
    logic [FUNCT_W-1:0] funct;
    logic               mem_ready;
    logic               reg_dst;
    logic               branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic               ir_write;
    logic               pc_write;
    logic               illegal;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  instr_op, funct, mem_ready,
        output reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write,
               alu_src, reg_write, ir_write, pc_write, illegal, state_dbg
    );

    modport slave (
        output instr_op, funct, mem_ready,
        input  reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write,
               alu_src, reg_write, ir_write, pc_write, illegal, state_dbg
    );

endinterface

// File: rtl/cs161_alu_op_decode.sv
// cs161_alu_op_decode: combinational R-type funct -> ALU select.
// Ports: funct (in), alu_op (out), funct_valid (out, 1 for a supported funct).
// Unsupported functs report funct_valid=0 and a harmless ADD select.
module cs161_alu_op_decode
    import cs161_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               funct_valid
);

    always_comb begin
        alu_op      = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/cs161_multicycle_control.sv
// cs161_multicycle_control: multi-cycle MIPS control FSM for cs161_datapath.
// Ports: clk, rst (synchronous, active-high), bus (cs161_multicycle_control_if.master).
// Outputs are decoded from the current state and the op/funct latched in DECODE;
// ir_write/pc_write additionally follow mem_ready during FETCH.
// Build option: CS161_CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// opcode/funct parks the FSM in TRAP with a sticky illegal flag; otherwise it
// is treated as a NOP and illegal stays 0.
module cs161_multicycle_control
    import cs161_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    cs161_multicycle_control_if.master    bus
);

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q;
    logic [FUNCT_W-1:0] funct_q;
    logic               illegal_q;

    logic [FUNCT_W-1:0] dec_funct_c;
    logic [ALUOP_W-1:0] dec_alu_op_c;
    logic               dec_funct_valid_c;
    logic               op_legal_c;

    logic               reg_dst_c, branch_c, mem_read_c, mem_to_reg_c;
    logic               mem_write_c, alu_src_c, reg_write_c, ir_write_c, pc_write_c;
    logic [ALUOP_W-1:0] alu_op_c;

    // Decoder sees the live IR field while dispatching, the latched one afterwards.
    assign dec_funct_c = (state_q == ST_DECODE) ? bus.funct : funct_q;

    cs161_alu_op_decode u_alu_op_decode (
        .funct       (dec_funct_c),
        .alu_op      (dec_alu_op_c),
        .funct_valid (dec_funct_valid_c)
    );

    // Legality of the instruction currently presented on the IR fields.
    always_comb begin
        if (bus.instr_op == OP_RTYPE) begin
            op_legal_c = dec_funct_valid_c;
        end else begin
            op_legal_c = is_known_itype(bus.instr_op);
        end
    end

    // State register and DECODE-time capture of op/funct.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q    <= bus.instr_op;
                funct_q <= bus.funct;
            end
        end
    end

`ifdef CS161_CTRL_ILLEGAL_TRAP_EN
    // Sticky flag, set on the edge that dispatches an illegal instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if ((state_q == ST_DECODE) && !op_legal_c) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign illegal_q = 1'b0;
`endif

    // Next-state and control-line decode.
    always_comb begin
        state_d      = state_q;
        reg_dst_c    = 1'b0;
        branch_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_to_reg_c = 1'b0;
        mem_write_c  = 1'b0;
        alu_src_c    = 1'b0;
        reg_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        alu_op_c     = ALU_AND;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read_c = 1'b1;
                alu_op_c   = ALU_ADD;
                ir_write_c = bus.mem_ready;
                pc_write_c = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_op_c = ALU_ADD;
                if (!op_legal_c) begin
`ifdef CS161_CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    case (bus.instr_op)
                        OP_RTYPE:     state_d = ST_EXEC_R;
                        OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                        OP_BEQ:       state_d = ST_BRANCH;
                        OP_ADDI:      state_d = ST_EXEC_I;
                        default:      state_d = ST_FETCH;
                    endcase
                end
            end
            ST_MEM_ADDR: begin
                alu_src_c = 1'b1;
                alu_op_c  = ALU_ADD;
                state_d   = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read_c = 1'b1;
                alu_src_c  = 1'b1;
                alu_op_c   = ALU_ADD;
                if (bus.mem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_WB_MEM: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_c = 1'b1;
                alu_src_c   = 1'b1;
                alu_op_c    = ALU_ADD;
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                alu_op_c = dec_alu_op_c;
                state_d  = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                alu_op_c    = dec_alu_op_c;
                state_d     = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_c = 1'b1;
                alu_op_c  = ALU_ADD;
                state_d   = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write_c = 1'b1;
                alu_src_c   = 1'b1;
                alu_op_c    = ALU_ADD;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                branch_c = 1'b1;
                alu_op_c = ALU_SUB;
                state_d  = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.reg_dst    = reg_dst_c;
    assign bus.branch     = branch_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.illegal    = illegal_q;
    assign bus.state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_cs161_multicycle_control.sv
// tb_cs161_multicycle_control: directed bench for cs161_multicycle_control.
// Each instruction is expanded into its expected per-cycle state path from the
// latency/stall rules; per-state output rules give the expected control word,
// which a negedge process compares against the DUT every cycle. A few literal
// expectations pin the model. Honors CS161_CTRL_ILLEGAL_TRAP_EN like the RTL.
module tb_cs161_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic reg_dst, branch, mem_read, mem_to_reg, mem_write;
        logic alu_src, reg_write, ir_write, pc_write, illegal;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cs161_multicycle_control_if bus();

    cs161_multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t seen[16];
    int   cnt[16];
    logic [5:0] m_fn  = 6'd0;
    logic       m_ill = 1'b0;
    int         m_next = 0;

    function automatic logic fn_ok(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b100111 || fn == 6'b101010;
    endfunction

    function automatic logic [3:0] rmap(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expected control word for a state, from the per-state output rules.
    function automatic vec_t model(input int st, input logic mr);
        vec_t e;
        e = '0;
        e.st = 4'(st);
        e.illegal = m_ill;
        case (st)
            1:  begin e.mem_read = 1; e.alu = 4'b0010; e.ir_write = mr; e.pc_write = mr; end
            2:  e.alu = 4'b0010;
            3:  begin e.alu_src = 1; e.alu = 4'b0010; end
            4:  begin e.mem_read = 1; e.alu_src = 1; e.alu = 4'b0010; end
            5:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            6:  begin e.mem_write = 1; e.alu_src = 1; e.alu = 4'b0010; end
            7:  e.alu = rmap(m_fn);
            8:  begin e.reg_write = 1; e.reg_dst = 1; e.alu = rmap(m_fn); end
            9:  begin e.alu_src = 1; e.alu = 4'b0010; end
            10: begin e.reg_write = 1; e.alu_src = 1; e.alu = 4'b0010; end
            11: begin e.branch = 1; e.alu = 4'b0110; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t dut_vec();
        return {bus.state_dbg, bus.alu_op, bus.reg_dst, bus.branch, bus.mem_read,
                bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write,
                bus.ir_write, bus.pc_write, bus.illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        vec_t e, d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = dut_vec();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL cycle t=%0t got st=%0d alu=%b flags=%b want st=%0d alu=%b flags=%b",
                         $time, d.st, d.alu, d[9:0], e.st, e.alu, e[9:0]);
            end
            if (!$isunknown(d.st)) begin
                seen[d.st] = d;
                cnt[d.st]++;
            end
        end
    end

    function automatic int total();
        int s = 0;
        for (int i = 1; i < 13; i++) s += cnt[i];
        return s;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) begin
            cnt[i]  = 0;
            seen[i] = 'x;
        end
    endtask

    task automatic step(input int st, input logic mr, input logic r,
                        input logic [5:0] op, input logic [5:0] fn);
        @(posedge clk);
        #1;
        rst           = r;
        bus.mem_ready = mr;
        bus.instr_op  = op;
        bus.funct     = fn;
        exp_q.push_back(model(st, mr));
    endtask

    task automatic junk(input int st, input logic mr, input logic r);
        step(st, mr, r, 6'($urandom), 6'($urandom));
    endtask

    task automatic release_rst();
        junk(0, 1'($urandom), 1'b0);
        m_next = 1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            junk(m_next, 1'b0, 1'b1);
            m_next = 0;
            m_ill  = 1'b0;
        end
        release_rst();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Expand one instruction into its expected state path.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fstall, input int mstall, input int abort_st);
        logic legal;
        legal = (op == 6'b000000 && fn_ok(fn)) || op == 6'b100011 || op == 6'b101011 ||
                op == 6'b000100 || op == 6'b001000;
        for (int i = 0; i < fstall; i++) step(1, 1'b0, 1'b0, op, fn);
        step(1, 1'b1, 1'b0, op, fn);
        m_fn = fn;
        step(2, 1'($urandom), 1'b0, op, fn);
        m_next = 1;
        if (!legal) begin
`ifdef CS161_CTRL_ILLEGAL_TRAP_EN
            m_ill = 1'b1;
            for (int i = 0; i < 3; i++) junk(12, 1'($urandom), 1'b0);
            m_next = 12;
`endif
            return;
        end
        case (op)
            6'b000000: begin junk(7, 1'($urandom), 0); junk(8, 1'($urandom), 0); end
            6'b100011: begin
                junk(3, 1'($urandom), 0);
                for (int i = 0; i < mstall; i++) junk(4, 1'b0, 0);
                junk(4, 1'b1, 0);
                junk(5, 1'($urandom), 0);
            end
            6'b101011: begin
                junk(3, 1'($urandom), 0);
                if (abort_st == 6) begin
                    junk(6, 1'b0, 1'b1);
                    m_next = 0;
                    m_ill  = 1'b0;
                    return;
                end
                for (int i = 0; i < mstall; i++) junk(6, 1'b0, 0);
                junk(6, 1'b1, 0);
            end
            6'b000100: junk(11, 1'($urandom), 0);
            default:   begin junk(9, 1'($urandom), 0); junk(10, 1'($urandom), 0); end
        endcase
    endtask

    logic [5:0] rfns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111};

    initial begin
        bus.mem_ready = 1'b0;
        bus.instr_op  = 6'd0;
        bus.funct     = 6'd0;
        clear_stats();

        do_reset(2);
        settle();
        chk("reset_idle_state", 32'(bus.state_dbg), 32'd0);
        chk("reset_idle_mem_read", 32'(bus.mem_read), 32'd0);

        // slt, no stalls
        clear_stats();
        run_instr(6'b000000, 6'b101010, 0, 0, 0);
        settle();
        chk("slt_exec_alu", 32'(seen[7].alu), 32'h7);
        chk("slt_exec_regwr", 32'(seen[7].reg_write), 32'd0);
        chk("slt_wb_regwr", 32'(seen[8].reg_write), 32'd1);
        chk("slt_wb_regdst", 32'(seen[8].reg_dst), 32'd1);
        chk("slt_cycles", 32'(total()), 32'd4);

        // add with two fetch stalls
        run_instr(6'b000000, 6'b100000, 2, 0, 0);

        // lw with three read stalls
        settle();
        clear_stats();
        run_instr(6'b100011, 6'($urandom), 0, 3, 0);
        settle();
        chk("lw_memrd_cycles", 32'(cnt[4]), 32'd4);
        chk("lw_cycles", 32'(total()), 32'd8);
        chk("lw_wb_mem_to_reg", 32'(seen[5].mem_to_reg), 32'd1);

        // sw with one write stall, then beq
        run_instr(6'b101011, 6'($urandom), 0, 1, 0);
        settle();
        clear_stats();
        run_instr(6'b000100, 6'($urandom), 0, 0, 0);
        settle();
        chk("beq_branch", 32'(seen[11].branch), 32'd1);
        chk("beq_alu", 32'(seen[11].alu), 32'h6);
        chk("beq_regwr", 32'(seen[11].reg_write), 32'd0);
        chk("beq_cycles", 32'(total()), 32'd3);

        // addi and the remaining R-type functs
        run_instr(6'b001000, 6'($urandom), 1, 0, 0);
        for (int i = 0; i < 5; i++) run_instr(6'b000000, rfns[i], 0, 0, 0);

        // illegal funct
        settle();
        clear_stats();
        run_instr(6'b000000, 6'b000001, 0, 0, 0);
        settle();
`ifdef CS161_CTRL_ILLEGAL_TRAP_EN
        chk("trap_illegal", 32'(seen[12].illegal), 32'd1);
        chk("trap_held", 32'(cnt[12]), 32'd3);
        do_reset(1);
        settle();
        chk("trap_cleared", 32'(bus.illegal), 32'd0);
`else
        chk("nop_cycles", 32'(total()), 32'd2);
        chk("nop_illegal", 32'(bus.illegal), 32'd0);
`endif

        // illegal opcode
        run_instr(6'b111111, 6'($urandom), 0, 0, 0);
        do_reset(1);

        // reset asserted mid-store while memory stalls
        run_instr(6'b101011, 6'($urandom), 0, 2, 6);
        release_rst();
        settle();
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_state", 32'(bus.state_dbg), 32'd0);
        run_instr(6'b001000, 6'($urandom), 0, 0, 0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
